mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_pkg.sv | 24 ++
 rtl/rr_arb2.sv | 26 ++
 rtl/mem_arbiter.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and constants for the memory arbiter
//
// Purpose: FSM state encoding, bus-owner enum and the default access timeout
//          shared by mem_arbiter and rr_arb2.
// Ports:   none (package).

package mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ADDR   = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_t;

    typedef enum logic {
        FETCH = 1'b0,
        DATA  = 1'b1
    } owner_t;

    localparam int TIMEOUT_DEFAULT = 15;
    localparam int CNT_W           = 8;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-input round-robin selector
//
// Purpose: picks one of two requesters; on a tie the one that was not
//          granted last wins.
// Ports:   req  - request vector, [0] = fetch, [1] = data
//          last - owner of the most recently completed transaction
//          gnt  - one-hot selection (zero when nothing requests)

module rr_arb2
    import mem_pkg::*;
(
    input  logic [1:0] req,
    input  owner_t     last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (req == 2'b11) begin
            gnt = (last == FETCH) ? 2'b10 : 2'b01;
        end else begin
            gnt = req;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data memory arbiter with timeout
//
// Purpose: arbitrates a fetch and a data requester onto one memory port,
//          drives the MAR/MDR strobes and aborts an access that waits too
//          long for the memory ready signal.
// Ports:   clk, rst_n                  - clock, async active-low reset
//          f_req/f_we/f_addr           - fetch request (read-only, f_we ignored)
//          d_req/d_we/d_addr/d_wdata   - data request
//          f_gnt/d_gnt                 - accept pulse (combinational in IDLE)
//          f_done/d_done               - completion pulse
//          err                         - timeout pulse to the current owner
//          rdata                       - read result, held until next read
//          MAR, MDR_OUT                - registered address / write data
//          MDR_IN, R                   - memory read data and ready
//          LDMAR, LDMDR, GATEMDR,
//          MEM_EN, R_W                 - memory control strobes

module mem_arbiter
    import mem_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT,
    parameter int AW      = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          f_req,
    input  logic          d_req,
    input  logic          f_we,
    input  logic          d_we,
    input  logic [AW-1:0] f_addr,
    input  logic [AW-1:0] d_addr,
    input  logic [AW-1:0] d_wdata,
    output logic          f_gnt,
    output logic          d_gnt,
    output logic          f_done,
    output logic          d_done,
    output logic          err,
    output logic [AW-1:0] rdata,
    output logic [AW-1:0] MAR,
    output logic [AW-1:0] MDR_OUT,
    input  logic [AW-1:0] MDR_IN,
    output logic          LDMAR,
    output logic          LDMDR,
    output logic          GATEMDR,
    output logic          MEM_EN,
    output logic          R_W,
    input  logic          R
);

    // Counter value seen in the last ACCESS cycle allowed before aborting.
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    state_t            state_q, state_d;
    owner_t            owner_q;
    owner_t            last_q;
    logic              we_q;
    logic [AW-1:0]     addr_q;
    logic [AW-1:0]     wdata_q;
    logic              err_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [1:0]        sel;
    logic              timeout_hit;

    // f_we is intentionally unused: fetches are always reads.
    logic              unused_f_we;
    assign unused_f_we = f_we;

    rr_arb2 u_rr (
        .req  ({d_req, f_req}),
        .last (last_q),
        .gnt  (sel)
    );

    assign timeout_hit = (cnt_q >= TO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        f_gnt   = 1'b0;
        d_gnt   = 1'b0;
        f_done  = 1'b0;
        d_done  = 1'b0;
        err     = 1'b0;
        LDMAR   = 1'b0;
        LDMDR   = 1'b0;
        GATEMDR = 1'b0;
        MEM_EN  = 1'b0;
        R_W     = 1'b0;
        case (state_q)
            IDLE: begin
                if (|sel) begin
                    state_d = ADDR;
                end
                // A request held through reset must not show a grant.
                f_gnt = sel[0] & rst_n;
                d_gnt = sel[1] & rst_n;
            end
            ADDR: begin
                LDMAR   = 1'b1;
                state_d = ACCESS;
            end
            ACCESS: begin
                MEM_EN = 1'b1;
                R_W    = we_q;
                if (R) begin
                    LDMDR   = ~we_q;
                    state_d = DONE;
                end else if (timeout_hit) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (err_q) begin
                    err = 1'b1;
                end else if (owner_q == DATA) begin
                    d_done = 1'b1;
                end else begin
                    f_done = 1'b1;
                end
                GATEMDR = ~err_q & ~we_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q <= FETCH;
            last_q  <= FETCH;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            MAR     <= '0;
            MDR_OUT <= '0;
            rdata   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|sel) begin
                        owner_q <= sel[1] ? DATA : FETCH;
                        we_q    <= sel[1] & d_we;
                        addr_q  <= sel[1] ? d_addr : f_addr;
                        wdata_q <= d_wdata;
                        err_q   <= 1'b0;
                        cnt_q   <= '0;
                    end
                end
                ADDR: begin
                    MAR   <= addr_q;
                    cnt_q <= '0;
                    if (we_q) begin
                        MDR_OUT <= wdata_q;
                    end
                end
                ACCESS: begin
                    // Saturating wait counter.
                    if (cnt_q != {CNT_W{1'b1}}) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                    if (R) begin
                        if (!we_q) begin
                            rdata <= MDR_IN;
                        end
                    end else if (timeout_hit) begin
                        err_q <= 1'b1;
                    end
                end
                DONE: begin
                    last_q <= owner_q;
                end
                default: ;
            endcase
        end
    end

endmodule
